// File: rtl/rle_compress_if.sv
// Word-in / run-length-out streaming bus for the bit-serial run-length encoder.
interface rle_compress_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/rle_compress.sv
// Bit-serial run-length encoder: scans 16-bit words LSB first and emits
// alternating 0-run / 1-run lengths, always starting with a run of 0s.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high
// SHIFT | examining one bit per cycle from shreg
// SAT   | run hit 16'hFFFF; emitting the zero-length opposite-digit run
// FLUSH | stream ended; emitting the final run with out_last
module rle_compress (
    input  logic          clk,
    input  logic          rst,
    rle_compress_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, SAT, FLUSH} state_t;

    state_t      state, state_n;
    logic [15:0] shreg, shreg_n;
    logic [3:0]  bitcnt, bitcnt_n;
    logic        last_q, last_n;
    logic        cur, cur_n;
    logic [15:0] run_len, run_n;

    logic [15:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;

    logic        slot_free;
    logic        bit_b;
    logic        adv;
    logic        emit;
    logic [15:0] emit_data;
    logic        emit_last;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bit_b        = shreg[bitcnt];
    assign bus.in_ready = (state == IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        last_n    = last_q;
        cur_n     = cur;
        run_n     = run_len;
        adv       = 1'b0;
        emit      = 1'b0;
        emit_data = '0;
        emit_last = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_n  = bus.in_data;
                    last_n   = bus.in_last;
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_b == cur && run_len != 16'hFFFF) begin
                    run_n = run_len + 16'd1;
                    adv   = 1'b1;
                end else if (slot_free) begin
                    emit = 1'b1;
                    if (bit_b == cur) begin
                        // bit is not consumed; it is re-examined after SAT
                        emit_data = 16'hFFFF;
                        state_n   = SAT;
                    end else begin
                        emit_data = run_len;
                        cur_n     = ~cur;
                        run_n     = 16'd1;
                        adv       = 1'b1;
                    end
                end
            end
            SAT: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_data = '0;
                    run_n     = '0;
                    state_n   = SHIFT;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_data = run_len;
                    emit_last = 1'b1;
                    cur_n     = 1'b0;
                    run_n     = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (adv) begin
            bitcnt_n = bitcnt + 4'd1;
            if (bitcnt == 4'd15)
                state_n = last_q ? FLUSH : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            last_q      <= 1'b0;
            cur         <= 1'b0;
            run_len     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            last_q  <= last_n;
            cur     <= cur_n;
            run_len <= run_n;
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= emit_data;
                out_last_q  <= emit_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rle_compress.sv
// Self-checking bench for rle_compress: directed and random streams checked
// against a run-splitting reference model built from the bit sequence.
module tb_rle_compress;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rle_compress_if bus ();

    rle_compress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int mode      = 0;   // 0: ready high, 1: random, 2: low for stall_cnt cycles, 3: low
    int stall_cnt = 0;

    bit          bitq[$];
    logic [16:0] expq[$];
    logic [16:0] rcv[$];
    logic [15:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int len, input bit last);
        int r;
        r = len;
        while (r > 65535) begin
            expq.push_back({1'b0, 16'hFFFF});
            expq.push_back({1'b0, 16'h0000});
            r -= 65535;
        end
        expq.push_back({last, r[15:0]});
    endtask

    // Maximal alternating runs starting with digit 0; long runs split into FFFF,0 pairs.
    task automatic build_exp();
        int digit;
        int len;
        expq.delete();
        digit = 0;
        len   = 0;
        foreach (bitq[i]) begin
            if (int'(bitq[i]) == digit) len++;
            else begin
                push_run(len, 1'b0);
                digit = 1 - digit;
                len   = 1;
            end
        end
        push_run(len, 1'b1);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom % 2);
                2: begin
                    if (stall_cnt > 0) begin
                        bus.out_ready = 1'b0;
                        stall_cnt--;
                    end else bus.out_ready = 1'b1;
                end
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: records transfers and checks held values while stalled.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 1'b0;
            else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_data", 32'(bus.out_data), 32'(prev_data));
                    chk("stall_last", 32'(bus.out_last), 32'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) rcv.push_back({bus.out_last, bus.out_data});
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    task automatic send_word(input logic [15:0] w, input bit last, output int busy);
        int guard;
        @(posedge clk);
        #1;
        bus.in_data  = w;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!bus.in_ready && busy < 1000) begin
            busy++;
            @(negedge clk);
        end
        if (guard >= 1000 || busy >= 1000) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_stream(input string name, input int mode_in);
        int busy;
        int guard;
        mode = mode_in;
        bitq.delete();
        rcv.delete();
        foreach (wq[i]) begin
            for (int b = 0; b < 16; b++) bitq.push_back(wq[i][b]);
            send_word(wq[i], i == wq.size() - 1, busy);
            if (mode_in == 0 && (i < 2 || i == wq.size() - 1))
                chk({name, "_busy"}, 32'(busy), (i == wq.size() - 1) ? 32'd17 : 32'd16);
        end
        build_exp();
        guard = 0;
        while (rcv.size() < expq.size() && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk({name, "_timeout"}, 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        chk({name, "_count"}, 32'(rcv.size()), 32'(expq.size()));
        foreach (expq[i])
            if (i < rcv.size()) chk($sformatf("%s_run%0d", name, i), 32'(rcv[i]), 32'(expq[i]));
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        wq = {16'h0000, 16'h0000};
        run_stream("zeros", 0);
        wq = {16'hFFFF};
        run_stream("ones", 0);
        wq = {16'h0001};
        run_stream("one_lsb", 0);
        wq = {16'h00F0};
        run_stream("f0", 0);
        wq = {16'h00F0};
        run_stream("f0_rand", 1);
        stall_cnt = 20;
        wq = {16'h00F0};
        run_stream("f0_hold", 2);
        wq = {16'hFF00, 16'h00FF};
        run_stream("cross", 0);

        for (int s = 0; s < 4; s++) begin
            int nw;
            nw = 1 + int'($urandom_range(3));
            wq.delete();
            for (int k = 0; k < nw; k++) wq.push_back(16'($urandom));
            run_stream($sformatf("rand%0d", s), 1);
        end

        wq.delete();
        repeat (4097) wq.push_back(16'h0000);
        run_stream("sat", 0);

        mode = 3;
        @(posedge clk);
        #1;
        bus.in_data  = 16'h00F0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", 32'(bus.out_data), 32'd0);
        chk("arst_out_last", 32'(bus.out_last), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        wq = {16'h00F0};
        run_stream("post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
